// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned 32x32 multiply / 32/32 divide sequencer.
// Borrows the shared ALU for one add (multiply) or subtract (divide) per cycle
// over 32 iterations and leaves a 64-bit {hi,lo} result.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             alu_own_o,
  output logic [WIDTH-1:0] alu_src_a_o,
  output logic [WIDTH-1:0] alu_src_b_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_res_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Multiply step helpers: carry out of hi + b, and the 33-bit partial sum.
  logic             mul_carry;
  logic [WIDTH:0]   mul_sum;
  // Divide step helpers: shifted partial remainder and its lost top bit.
  logic [WIDTH-1:0] div_rs;
  logic             div_m;
  logic             div_ok;

  assign mul_carry = (alu_res_i < hi_q);
  assign mul_sum   = lo_q[0] ? {mul_carry, alu_res_i} : {1'b0, hi_q};

  assign div_rs = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign div_m  = hi_q[WIDTH-1];
  // With m set the true remainder is >= 2^WIDTH, so the subtract always succeeds.
  assign div_ok = div_m | (alu_res_i <= div_rs);

  // Status outputs are pure decodes of the state.
  always_comb begin
    busy_o    = (state_q != StIdle);
    done_o    = (state_q == StDone);
    alu_own_o = (state_q == StMul) || (state_q == StDiv);
    hi_o      = hi_q;
    lo_o      = lo_q;
  end

  // Next-state, datapath update and ALU operand drive.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    count_d     = count_q;
    alu_src_a_o = '0;
    alu_src_b_o = '0;
    alu_ctrl_o  = AluAdd;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          count_d = '0;
          b_d     = op_b_i;
          if (!op_div_i) begin
            hi_d    = '0;
            lo_d    = op_a_i;
            state_d = StMul;
          end else if (op_b_i != '0) begin
            hi_d    = '0;
            lo_d    = op_a_i;
            state_d = StDiv;
          end else begin
            // Divide by zero: finish immediately with a recognisable result.
            hi_d    = op_a_i;
            lo_d    = '1;
            state_d = StDone;
          end
        end
      end

      StMul: begin
        alu_src_a_o = hi_q;
        alu_src_b_o = b_q;
        alu_ctrl_o  = AluAdd;
        // {hi,lo} <= {sum, lo[W-1:1]}: consumed multiplier bit falls off the bottom.
        hi_d        = mul_sum[WIDTH:1];
        lo_d        = {mul_sum[0], lo_q[WIDTH-1:1]};
        count_d     = count_q + CNT_W'(1);
        if (count_q == LastIter) begin
          state_d = StDone;
        end
      end

      StDiv: begin
        alu_src_a_o = div_rs;
        alu_src_b_o = b_q;
        alu_ctrl_o  = AluSub;
        hi_d        = div_ok ? alu_res_i : div_rs;
        lo_d        = {lo_q[WIDTH-2:0], div_ok};
        count_d     = count_q + CNT_W'(1);
        if (count_q == LastIter) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural model of the shared ALU.
module tb_alu_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        op_div_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        alu_own_o;
  logic [31:0] alu_src_a_o;
  logic [31:0] alu_src_b_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_res_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  // Shared ALU model: add / sub, combinational.
  always_comb begin
    alu_res_i = '0;
    if (alu_ctrl_o == 3'b010) alu_res_i = alu_src_a_o + alu_src_b_o;
    else if (alu_ctrl_o == 3'b110) alu_res_i = alu_src_a_o - alu_src_b_o;
  end

  alu_muldiv_seq #(
    .WIDTH(32),
    .CNT_W(5)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_div_i   (op_div_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .alu_own_o  (alu_own_o),
    .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o),
    .alu_ctrl_o (alu_ctrl_o),
    .alu_res_i  (alu_res_i)
  );

  typedef struct {
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  localparam int NumVec = 11;
  vec_t vecs[NumVec];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation; cycle k=1 is the cycle right after the accepting edge.
  // inj_at pulses an extra start, rst_at asserts reset (left high on return).
  task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input int rst_at,
                        output logic [31:0] r_hi, output logic [31:0] r_lo,
                        output int lat, output logic own_seen);
    lat      = 0;
    own_seen = 1'b0;
    op_div_i = div;
    op_a_i   = a;
    op_b_i   = b;
    start_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    op_div_i = 1'b0;
    op_a_i   = '0;
    op_b_i   = '0;
    for (int k = 1; k <= 40; k++) begin
      if (alu_own_o) own_seen = 1'b1;
      if (done_o) begin
        lat = k;
        break;
      end
      if (k == rst_at) begin
        rst_i = 1'b1;
        break;
      end
      if (k == inj_at) begin
        start_i  = 1'b1;
        op_div_i = 1'b0;
        op_a_i   = 32'd3;
        op_b_i   = 32'd3;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    r_hi = hi_o;
    r_lo = lo_o;
  endtask

  logic [31:0] r_hi, r_lo;
  int          lat;
  logic        own;

  initial begin
    vecs[0]  = '{1'b0, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A, 33};
    vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[2]  = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 33};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 33};
    vecs[4]  = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 33};
    vecs[5]  = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 33};
    vecs[7]  = '{1'b1, 32'd7,         32'd100,       32'd7,         32'd0,         33};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'd3,         32'd2,         32'h2AAA_AAAA, 33};
    vecs[9]  = '{1'b1, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33};

    rst_i    = 1'b1;
    start_i  = 1'b0;
    op_div_i = 1'b0;
    op_a_i   = '0;
    op_b_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_own", 64'(alu_own_o), 64'd0);
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    check("reset_alu_ops", {alu_src_a_o, alu_src_b_o}, 64'd0);
    check("reset_alu_ctrl", 64'(alu_ctrl_o), 64'd2);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < NumVec; i++) begin
      run_op(vecs[i].div, vecs[i].a, vecs[i].b, -1, -1, r_hi, r_lo, lat, own);
      check($sformatf("v%0d_hi", i), 64'(r_hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(r_lo), 64'(vecs[i].lo));
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_alu_own_seen", i), 64'(own), 64'(vecs[i].lat != 1));
      @(posedge clk_i); #1;
      check($sformatf("v%0d_after_done_busy", i), {63'd0, busy_o | done_o}, 64'd0);
      check($sformatf("v%0d_hold", i), {hi_o, lo_o}, {vecs[i].hi, vecs[i].lo});
    end

    // Start pulsed mid-multiply must be ignored.
    run_op(1'b0, 32'h0000_1000, 32'h0000_1000, 10, -1, r_hi, r_lo, lat, own);
    check("ignore_start_hi", 64'(r_hi), 64'h0);
    check("ignore_start_lo", 64'(r_lo), 64'h0100_0000);
    check("ignore_start_latency", 64'(lat), 64'd33);
    @(posedge clk_i); #1;
    check("ignore_start_idle", {63'd0, busy_o}, 64'd0);

    // Reset mid-multiply aborts with no done pulse, then a fresh operation runs clean.
    run_op(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, -1, 5, r_hi, r_lo, lat, own);
    check("abort_no_done", 64'(lat), 64'd0);
    @(posedge clk_i); #1;
    check("abort_busy", {62'd0, busy_o, done_o}, 64'd0);
    check("abort_hilo", {hi_o, lo_o}, 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    run_op(1'b0, 32'd6, 32'd7, -1, -1, r_hi, r_lo, lat, own);
    check("post_abort_hi", 64'(r_hi), 64'h0);
    check("post_abort_lo", 64'(r_lo), 64'd42);
    check("post_abort_latency", 64'(lat), 64'd33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
